// File: rtl/accel_dma_line_server_pkg.sv
// Shared definitions for the accelerator DMA line server: default widths,
// line geometry and the server state encoding.
package accel_dma_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int MEM_W_DEF  = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_BYTES = LINE_W_DEF / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } dma_srv_state_t;

endpackage

// File: rtl/accel_dma_line_server_if.sv
// Bundle of the DMA line-read port (accelerator side) and the narrow beat
// port (memory side). The slave view is the line server itself; the master
// view is its environment (accelerator plus memory arbiter).
interface accel_dma_line_server_if
  import accel_dma_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int MEM_W  = MEM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] dma_addr;
  logic              dma_re;
  logic              dma_req_ready;
  logic              dma_resp_valid;
  logic [LINE_W-1:0] dma_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_resp_valid;
  logic [MEM_W-1:0]  mem_rdata;
  logic              proto_err;

  modport slave (
    input  dma_addr, dma_re, mem_req_ready, mem_resp_valid, mem_rdata,
    output dma_req_ready, dma_resp_valid, dma_rdata, mem_req_valid, mem_addr,
           proto_err
  );

  modport master (
    output dma_addr, dma_re, mem_req_ready, mem_resp_valid, mem_rdata,
    input  dma_req_ready, dma_resp_valid, dma_rdata, mem_req_valid, mem_addr,
           proto_err
  );

endinterface

// File: rtl/accel_dma_line_server.sv
// Memory-side responder for the accelerator's wide DMA read port. One line
// request is accepted at a time, fetched as BEATS sequential narrow beats
// (issue and return may overlap) and returned as a one-cycle wide pulse.
module accel_dma_line_server
  import accel_dma_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int MEM_W  = MEM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                     clk,
  input logic                     reset,
  accel_dma_line_server_if.slave  bus
);

  localparam int BEATS   = LINE_W / MEM_W;
  localparam int IDX_W   = $clog2(BEATS);
  localparam int CNT_W   = IDX_W + 1;
  localparam int L_BYTES = LINE_W / 8;
  localparam int W_BYTES = MEM_W / 8;

  localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'(L_BYTES - 1));
  localparam logic [CNT_W-1:0]  BEATS_C   = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(BEATS - 1);

  dma_srv_state_t    r_state;
  dma_srv_state_t    w_state_nxt;

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_iss_cnt;
  logic [CNT_W-1:0]  r_rsp_cnt;
  logic [MEM_W-1:0]  r_line [BEATS];
  logic [LINE_W-1:0] r_rdata;
  logic              r_proto_err;

  logic              w_ready;
  logic              w_resp_valid;
  logic              w_mem_req;
  logic              w_accept;
  logic              w_issue;
  logic              w_beat_ok;
  logic              w_beat_bad;
  logic              w_last_beat;
  logic [IDX_W-1:0]  w_slot;
  logic [LINE_W-1:0] w_line_full;

  // A beat counts only while fetching and while one is actually outstanding;
  // anything else is a protocol violation and is dropped.
  assign w_accept    = (r_state == IDLE) && bus.dma_re;
  assign w_issue     = w_mem_req && bus.mem_req_ready;
  assign w_beat_ok   = bus.mem_resp_valid && (r_state == FETCH) &&
                       (r_rsp_cnt != r_iss_cnt);
  assign w_beat_bad  = bus.mem_resp_valid && !w_beat_ok;
  assign w_last_beat = w_beat_ok && (r_rsp_cnt == LAST_C);
  assign w_slot      = r_rsp_cnt[IDX_W-1:0];

  // Next-state and handshake outputs; ready drops immediately with reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b0;
    w_resp_valid = 1'b0;
    w_mem_req    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = !reset;
        if (bus.dma_re) w_state_nxt = FETCH;
      end
      FETCH: begin
        w_mem_req = (r_iss_cnt < BEATS_C);
        if (w_last_beat) w_state_nxt = RESP;
      end
      RESP: begin
        w_resp_valid = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line image including the beat arriving this cycle, so the final beat can
  // be folded straight into the output register.
  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      w_line_full[i*MEM_W +: MEM_W] = r_line[i];
    end
    if (w_beat_ok) begin
      w_line_full[int'(w_slot)*MEM_W +: MEM_W] = bus.mem_rdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Line base capture and issue/return beat counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base    <= '0;
      r_iss_cnt <= '0;
      r_rsp_cnt <= '0;
    end else if (w_accept) begin
      r_base    <= bus.dma_addr & BASE_MASK;
      r_iss_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      if (w_issue)   r_iss_cnt <= r_iss_cnt + CNT_W'(1);
      if (w_beat_ok) r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
    end
  end

  // Line assembly: each returned beat lands in the slot given by its order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BEATS; i++) r_line[i] <= '0;
    end else if (w_beat_ok) begin
      r_line[w_slot] <= bus.mem_rdata;
    end
  end

  // Output line register, loaded with the last beat and held until the next line.
  always_ff @(posedge clk) begin
    if (reset)            r_rdata <= '0;
    else if (w_last_beat) r_rdata <= w_line_full;
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)           r_proto_err <= 1'b0;
    else if (w_beat_bad) r_proto_err <= 1'b1;
  end

  assign bus.dma_req_ready  = w_ready;
  assign bus.dma_resp_valid = w_resp_valid;
  assign bus.dma_rdata      = r_rdata;
  assign bus.mem_req_valid  = w_mem_req;
  assign bus.mem_addr       = w_mem_req ?
                              (r_base + ADDR_W'(r_iss_cnt) * ADDR_W'(W_BYTES)) :
                              '0;
  assign bus.proto_err      = r_proto_err;

endmodule

// File: tb/tb_accel_dma_line_server.sv
// Bench for accel_dma_line_server: table-driven line reads, directed corner
// sequences and randomized reads against a memory model in which the word
// at byte address A reads as A ^ salt.
module tb_accel_dma_line_server;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  accel_dma_line_server_if bus ();
  accel_dma_line_server dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model controls and logs.
  int          mem_lat  = 1;
  int          mem_mode = 0;
  logic [31:0] mem_salt = '0;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t        pend[$];
  pend_t        pp;
  logic [31:0]  iss_log[$];
  logic [255:0] rsp_data[$];
  int           rsp_cyc[$];
  int           beats_ret = 0;
  int           stray_req = 0;
  int           stray_ack = 0;
  int           stray_cyc = 0;

  // Memory responder and output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = '0;
    end else begin
      case (mem_mode)
        0:       bus.mem_req_ready = 1'b1;
        1:       bus.mem_req_ready = (cyc % 2 == 0);
        default: bus.mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        iss_log.push_back(bus.mem_addr);
        pend.push_back('{bus.mem_addr, cyc + mem_lat});
      end
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = '0;
      if (stray_req != stray_ack) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hDEADBEEF;
        stray_ack          = stray_ack + 1;
        stray_cyc          = cyc;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        pp = pend.pop_front();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = pp.addr ^ mem_salt;
        beats_ret          = beats_ret + 1;
      end
    end
    if (bus.dma_resp_valid) begin
      rsp_data.push_back(bus.dma_rdata);
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] model_line(input logic [31:0] addr, input logic [31:0] salt);
    logic [255:0] r;
    logic [31:0]  b;
    b = addr & ~32'h1F;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = (b + 32'(i * 4)) ^ salt;
    return r;
  endfunction

  // One complete line read with all per-line checks.
  task automatic do_read(input logic [31:0] addr, input int lat, input int mode,
                         input logic [31:0] salt, input logic [31:0] ef,
                         input logic [31:0] el, input int elat, input logic eperr);
    int n_rsp, n_iss, t0, k;
    logic mono;
    mem_lat  = lat;
    mem_mode = mode;
    mem_salt = salt;
    @(negedge clk);
    k = 0;
    while (!bus.dma_req_ready && k < 40) begin @(negedge clk); k++; end
    n_rsp = rsp_data.size();
    n_iss = iss_log.size();
    chk("ready_before", bus.dma_req_ready, 1'b1);
    bus.dma_addr = addr;
    bus.dma_re   = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.dma_re = 1'b0;
    chk("ready_in_fetch", bus.dma_req_ready, 1'b0);
    k = 0;
    while (rsp_data.size() == n_rsp && k < 300) begin @(posedge clk); k++; end
    if (rsp_data.size() == n_rsp) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    chk("ready_after", bus.dma_req_ready, 1'b1);
    if (elat >= 0) begin
      chk("resp_latency", rsp_cyc[n_rsp] - t0, elat);
      chk("ready_latency", cyc - t0, elat + 1);
    end
    chk("issue_count", iss_log.size() - n_iss, 8);
    if (iss_log.size() - n_iss == 8) begin
      chk("first_addr", iss_log[n_iss], ef);
      chk("last_addr", iss_log[n_iss + 7], el);
      mono = 1'b1;
      for (int i = 1; i < 8; i++)
        if (iss_log[n_iss + i] <= iss_log[n_iss + i - 1]) mono = 1'b0;
      chk("addr_monotonic", mono, 1'b1);
    end
    chk("line_data", rsp_data[n_rsp], model_line(addr, salt));
    chk("word0", rsp_data[n_rsp][31:0], ef ^ salt);
    chk("word7", rsp_data[n_rsp][255:224], el ^ salt);
    repeat (3) @(negedge clk);
    chk("single_pulse", rsp_data.size() - n_rsp, 1);
    chk("rdata_held", bus.dma_rdata, model_line(addr, salt));
    chk("proto_err", bus.proto_err, eperr);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          mode;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_lat;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int k, acc, bad_rdy, n0;
    logic [31:0] a, s;
    tbl[0] = '{32'h0000_1004, 1, 0, 32'h0000_1000, 32'h0000_101C, 10};
    tbl[1] = '{32'h0000_2008, 3, 1, 32'h0000_2000, 32'h0000_201C, -1};
    tbl[2] = '{32'hFFFF_FFE0, 1, 0, 32'hFFFF_FFE0, 32'hFFFF_FFFC, 10};
    tbl[3] = '{32'h1234_567F, 2, 2, 32'h1234_5660, 32'h1234_567C, -1};

    bus.dma_addr = '0;
    bus.dma_re   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.dma_req_ready, 1'b0);
    chk("rst_resp_valid", bus.dma_resp_valid, 1'b0);
    chk("rst_rdata", bus.dma_rdata, '0);
    chk("rst_mem_req", bus.mem_req_valid, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_proto", bus.proto_err, 1'b0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", bus.dma_req_ready, 1'b1);

    for (int i = 0; i < 4; i++)
      do_read(tbl[i].addr, tbl[i].lat, tbl[i].mode, 32'h0,
              tbl[i].exp_first, tbl[i].exp_last, tbl[i].exp_lat, 1'b0);

    // dma_re held high: two back-to-back lines, nothing extra accepted.
    mem_mode = 0; mem_lat = 1; mem_salt = 32'h5A5A_0000;
    @(negedge clk);
    n0 = rsp_data.size();
    bus.dma_addr = 32'h0000_2000;
    bus.dma_re   = 1'b1;
    acc = 0; bad_rdy = 0; k = 0;
    while (k < 100 && !(acc >= 2 && rsp_data.size() - n0 >= 2)) begin
      if (acc == 1) bus.dma_addr = 32'h0000_2020;
      if (acc >= 2) bus.dma_re = 1'b0;
      if (bus.dma_re && bus.dma_req_ready) acc++;
      else if (acc > rsp_data.size() - n0 && bus.dma_req_ready) bad_rdy++;
      @(negedge clk);
      k++;
    end
    bus.dma_re = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_accepts", acc, 2);
    chk("hold_ready_low", bad_rdy, 0);
    chk("hold_resp_count", rsp_data.size() - n0, 2);
    if (rsp_data.size() - n0 >= 2) begin
      chk("hold_line0", rsp_data[n0], model_line(32'h2000, 32'h5A5A_0000));
      chk("hold_line1", rsp_data[n0 + 1], model_line(32'h2020, 32'h5A5A_0000));
    end

    // Stray beat while idle.
    chk("proto_before_stray", bus.proto_err, 1'b0);
    n0 = rsp_data.size();
    @(negedge clk);
    stray_req = stray_req + 1;
    k = 0;
    while (stray_ack != stray_req && k < 10) begin @(posedge clk); k++; end
    @(negedge clk);
    chk("stray_timing", cyc, stray_cyc + 1);
    chk("proto_set", bus.proto_err, 1'b1);
    chk("stray_no_resp", rsp_data.size() - n0, 0);
    do_read(32'h0000_5010, 1, 0, 32'h0, 32'h0000_5000, 32'h0000_501C, 10, 1'b1);

    // Reset after four beats returned.
    mem_mode = 0; mem_lat = 2; mem_salt = 32'h0;
    @(negedge clk);
    n0 = beats_ret;
    bus.dma_addr = 32'h0000_4000;
    bus.dma_re   = 1'b1;
    @(negedge clk);
    bus.dma_re = 1'b0;
    k = 0;
    while (beats_ret - n0 < 4 && k < 50) begin @(posedge clk); k++; end
    chk("mid_beats", beats_ret - n0, 4);
    n0 = rsp_data.size();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_ready", bus.dma_req_ready, 1'b0);
    chk("mid_rst_valid", bus.dma_resp_valid, 1'b0);
    chk("mid_rst_rdata", bus.dma_rdata, '0);
    chk("mid_rst_mem_req", bus.mem_req_valid, 1'b0);
    chk("mid_rst_mem_addr", bus.mem_addr, '0);
    chk("mid_rst_proto", bus.proto_err, 1'b0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_no_resp", rsp_data.size() - n0, 0);
    do_read(32'h0000_3000, 1, 0, 32'h0, 32'h0000_3000, 32'h0000_301C, 10, 1'b0);

    // Randomized reads.
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      s = $urandom;
      do_read(a, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), s,
              a & 32'hFFFF_FFE0, (a & 32'hFFFF_FFE0) + 32'd28, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
